// File: rtl/merge6_node.sv
// merge6_node: two-to-one merge node on the upward (leaf-to-root) path of the
// tree NoC. Two child channels are arbitrated round-robin. For each winning
// packet a one-bit side token naming the child goes out on S, followed by the
// unmodified packet on Out. All channels use valid/ready handshakes.
module merge6_node #(
   parameter int W = 9
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [W-1:0] In0_data,
   input  logic         In0_valid,
   output logic         In0_ready,
   input  logic [W-1:0] In1_data,
   input  logic         In1_valid,
   output logic         In1_ready,
   output logic         S_data,
   output logic         S_valid,
   input  logic         S_ready,
   output logic [W-1:0] Out_data,
   output logic         Out_valid,
   input  logic         Out_ready
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_S   = 2'd1,
      SEND_OUT = 2'd2
   } state_t;

   state_t         r_state;
   logic           r_prio;
   logic           r_winQ;
   logic [W-1:0]   r_pktQ;
   logic           r_sValid;
   logic           r_outValid;

   logic           w_idle;
   logic           w_anyValid;
   logic           w_win;
   logic [W-1:0]   w_winData;
   logic           w_grant0;
   logic           w_grant1;
   logic           w_accept;

   // Grant decode: a lone requester always wins, contention is settled by
   // r_prio. Readies are forced low outside IDLE and while RESET is high, so
   // at most one child ever sees ready.
   always_comb begin
      w_idle     = (r_state == IDLE) && !RESET;
      w_anyValid = In0_valid || In1_valid;
      if (In0_valid && In1_valid) begin
         w_win = r_prio;
      end else begin
         w_win = In1_valid;
      end
      w_winData = w_win ? In1_data : In0_data;
      w_grant0  = w_idle && w_anyValid && !w_win;
      w_grant1  = w_idle && w_anyValid && w_win;
      w_accept  = w_grant0 || w_grant1;
   end

   assign In0_ready = w_grant0;
   assign In1_ready = w_grant1;
   assign S_valid   = r_sValid;
   assign S_data    = r_winQ;
   assign Out_valid = r_outValid;
   assign Out_data  = r_pktQ;

   // Token-then-packet FSM; holding r_pktQ and r_winQ untouched outside the
   // accept edge keeps both output payloads stable while their valid is high.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= IDLE;
         r_prio     <= 1'b0;
         r_winQ     <= 1'b0;
         r_pktQ     <= '0;
         r_sValid   <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_pktQ   <= w_winData;
                  r_winQ   <= w_win;
                  r_prio   <= ~w_win;
                  r_sValid <= 1'b1;
                  r_state  <= SEND_S;
               end
            end
            SEND_S: begin
               if (S_ready) begin
                  r_sValid   <= 1'b0;
                  r_outValid <= 1'b1;
                  r_state    <= SEND_OUT;
               end
            end
            SEND_OUT: begin
               if (Out_ready) begin
                  r_outValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_sValid   <= 1'b0;
               r_outValid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_merge6_node.sv
// tb_merge6_node: self-checking bench for merge6_node. A table of single
// packet vectors plus hand-written sequences for burst contention,
// backpressure and mid-packet reset. Expected tokens and packets go into a
// scoreboard queue at grant time and are compared when S/Out transfer.
module tb_merge6_node;

   logic       CLK;
   logic       RESET;
   logic [8:0] In0_data;
   logic       In0_valid;
   logic       In0_ready;
   logic [8:0] In1_data;
   logic       In1_valid;
   logic       In1_ready;
   logic       S_data;
   logic       S_valid;
   logic       S_ready;
   logic [8:0] Out_data;
   logic       Out_valid;
   logic       Out_ready;

   typedef struct {
      logic       v0;
      logic [8:0] d0;
      logic       v1;
      logic [8:0] d1;
      logic       expWin;
      logic [8:0] expData;
   } vec_t;

   typedef struct {
      logic       tok;
      logic [8:0] data;
   } exp_t;

   vec_t vecs [10];
   exp_t sb [$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   merge6_node #(.W(9)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .In0_data  (In0_data),
      .In0_valid (In0_valid),
      .In0_ready (In0_ready),
      .In1_data  (In1_data),
      .In1_valid (In1_valid),
      .In1_ready (In1_ready),
      .S_data    (S_data),
      .S_valid   (S_valid),
      .S_ready   (S_ready),
      .Out_data  (Out_data),
      .Out_valid (Out_valid),
      .Out_ready (Out_ready)
   );

   // Free-running clock, 10 time units per cycle
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cycle counter used for latency measurement
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic failNow(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: got no event, want event (cycle %0d)", name, cyc);
   endtask

   // Scoreboard monitor, sampling at the falling edge; a transfer seen here
   // happens at the next rising edge since inputs only move just after it.
   always @(negedge CLK) begin
      if (RESET) begin
         checkOutput("ready_in_reset", {7'd0, In1_ready, In0_ready}, 9'd0);
      end else begin
         checkOutput("valid_excl", {8'd0, S_valid && Out_valid}, 9'd0);
         checkOutput("ready_excl", {8'd0, In0_ready && In1_ready}, 9'd0);
         if (S_valid && S_ready) begin
            if (sb.size() == 0) failNow("S_unexpected");
            else checkOutput("S_token", {8'd0, S_data}, {8'd0, sb[0].tok});
         end
         if (Out_valid && Out_ready) begin
            if (sb.size() == 0) failNow("Out_unexpected");
            else begin
               checkOutput("Out_data", Out_data, sb[0].data);
               void'(sb.pop_front());
            end
         end
      end
   end

   // Global safety net so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Offer one packet, wait for the grant, check which child won and queue
   // the expected token and packet.
   task automatic applyStimulus(input logic v0, input logic [8:0] d0, input logic v1, input logic [8:0] d1,
                                input logic expWin, input logic [8:0] expData, input string name, input bit hold);
      bit granted;
      granted   = 1'b0;
      In0_valid = v0;
      In0_data  = d0;
      In1_valid = v1;
      In1_data  = d1;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (In0_ready || In1_ready) begin
            granted = 1'b1;
            break;
         end
         @(posedge CLK); #1;
      end
      if (granted) begin
         checkOutput(name, {7'd0, In1_ready, In0_ready}, expWin ? 9'd2 : 9'd1);
         sb.push_back('{tok: expWin, data: expData});
         @(posedge CLK); #1;
      end else begin
         failNow({name, "_timeout"});
      end
      if (!hold) begin
         In0_valid = 1'b0;
         In1_valid = 1'b0;
      end
   endtask

   // Wait (bounded) until every queued packet has left on Out
   task automatic drain(input string name);
      for (int c = 0; c < 40; c++) begin
         if (sb.size() == 0) break;
         @(posedge CLK); #1;
      end
      if (sb.size() != 0) begin
         failNow({name, "_drain_timeout"});
         sb.delete();
      end
   endtask

   initial begin
      int c0;

      vecs[0] = '{1'b1, 9'h1A5, 1'b0, 9'h000, 1'b0, 9'h1A5};
      vecs[1] = '{1'b1, 9'h011, 1'b1, 9'h122, 1'b1, 9'h122};
      vecs[2] = '{1'b1, 9'h011, 1'b1, 9'h122, 1'b0, 9'h011};
      vecs[3] = '{1'b1, 9'h011, 1'b1, 9'h122, 1'b1, 9'h122};
      vecs[4] = '{1'b0, 9'h000, 1'b1, 9'h0AA, 1'b1, 9'h0AA};
      vecs[5] = '{1'b0, 9'h000, 1'b1, 9'h155, 1'b1, 9'h155};
      vecs[6] = '{1'b1, 9'h033, 1'b1, 9'h144, 1'b0, 9'h033};
      vecs[7] = '{1'b1, 9'h1FF, 1'b0, 9'h000, 1'b0, 9'h1FF};
      vecs[8] = '{1'b1, 9'h000, 1'b1, 9'h1FF, 1'b1, 9'h1FF};
      vecs[9] = '{1'b0, 9'h000, 1'b1, 9'h100, 1'b1, 9'h100};

      RESET     = 1'b1;
      In0_valid = 1'b1;
      In0_data  = 9'h0AB;
      In1_valid = 1'b1;
      In1_data  = 9'h1CD;
      S_ready   = 1'b1;
      Out_ready = 1'b1;

      // Reset state with both children requesting
      repeat (2) begin
         @(posedge CLK); #1;
      end
      @(negedge CLK);
      checkOutput("rst_S_valid", {8'd0, S_valid}, 9'd0);
      checkOutput("rst_S_data", {8'd0, S_data}, 9'd0);
      checkOutput("rst_Out_valid", {8'd0, Out_valid}, 9'd0);
      checkOutput("rst_Out_data", Out_data, 9'd0);
      @(posedge CLK); #1;
      RESET     = 1'b0;
      In0_valid = 1'b0;
      In1_valid = 1'b0;
      @(posedge CLK); #1;

      // Table of single packets, sinks always ready
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1,
                       vecs[i].expWin, vecs[i].expData, $sformatf("vec%0d_grant", i), 1'b0);
         drain($sformatf("vec%0d", i));
      end

      // Sustained contention: six packets, alternating, one per 3 cycles
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) sb.push_back('{tok: 1'b0, data: 9'h011});
         else            sb.push_back('{tok: 1'b1, data: 9'h122});
      end
      c0        = cyc;
      In0_valid = 1'b1;
      In0_data  = 9'h011;
      In1_valid = 1'b1;
      In1_data  = 9'h122;
      drain("burst");
      In0_valid = 1'b0;
      In1_valid = 1'b0;
      checkOutput("burst_cycles", 9'(cyc - c0), 9'd18);

      // Backpressure on S for 4 cycles, then on Out for 3 cycles
      S_ready   = 1'b0;
      Out_ready = 1'b1;
      applyStimulus(1'b1, 9'h0C3, 1'b0, 9'h000, 1'b0, 9'h0C3, "bp_grant", 1'b0);
      In1_valid = 1'b1;
      In1_data  = 9'h1C3;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         checkOutput("bp_S_valid", {8'd0, S_valid}, 9'd1);
         checkOutput("bp_S_data", {8'd0, S_data}, 9'd0);
         checkOutput("bp_S_noaccept", {8'd0, In1_ready}, 9'd0);
         @(posedge CLK); #1;
      end
      S_ready   = 1'b1;
      Out_ready = 1'b0;
      @(posedge CLK); #1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         checkOutput("bp_Out_valid", {8'd0, Out_valid}, 9'd1);
         checkOutput("bp_Out_data", Out_data, 9'h0C3);
         checkOutput("bp_Out_S_low", {8'd0, S_valid}, 9'd0);
         checkOutput("bp_Out_noaccept", {8'd0, In1_ready}, 9'd0);
         @(posedge CLK); #1;
      end
      Out_ready = 1'b1;
      drain("bp");
      In1_valid = 1'b0;
      @(posedge CLK); #1;

      // Reset pulse while a packet waits in SEND_OUT
      S_ready   = 1'b1;
      Out_ready = 1'b0;
      applyStimulus(1'b1, 9'h0F0, 1'b0, 9'h000, 1'b0, 9'h0F0, "rs_grant", 1'b0);
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput("rs_Out_valid_pre", {8'd0, Out_valid}, 9'd1);
      @(posedge CLK); #1;
      RESET     = 1'b1;
      In0_valid = 1'b1;
      In1_valid = 1'b1;
      @(posedge CLK); #1;
      RESET     = 1'b0;
      In0_valid = 1'b0;
      In1_valid = 1'b0;
      Out_ready = 1'b1;
      sb.delete();
      @(negedge CLK);
      checkOutput("rs_Out_valid_post", {8'd0, Out_valid}, 9'd0);
      checkOutput("rs_S_valid_post", {8'd0, S_valid}, 9'd0);
      checkOutput("rs_Out_data_post", Out_data, 9'd0);
      @(posedge CLK); #1;
      applyStimulus(1'b1, 9'h05A, 1'b1, 9'h1A0, 1'b0, 9'h05A, "rs_prio_grant", 1'b0);
      drain("rs");
      repeat (3) begin
         @(posedge CLK); #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
